life_gen_controller: RTL
========================

LIFE_GEN_CONTROLLER -- requirements
Module: life_gen_controller

Interface
REQ-001 SHALL have parameter GEN_W, default 16, width of generation counter.
REQ-002 SHALL have parameter PERIOD_W, default 8, width of period input.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 run  input  1  level; free-running generation mode while high.
REQ-006 step  input  1  single-generation request; level sampled each cycle.
REQ-007 clear  input  1  board-clear request; level sampled each cycle.
REQ-008 period  input  PERIOD_W  8-tick frames per generation; 0 treated as 1.
REQ-009 tick  input  3  current tick (0-7) from the 8-tick timer driven by timer_rst.
REQ-010 timer_rst  output  1  holds the 8-tick timer in reset (timer reads 0 while high, 1 on first edge after release).
REQ-011 load_en  output  1  one-cycle strobe commanding cells to latch next state.
REQ-012 clear_en  output  1  commands cells to clear.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 gen_count  output  GEN_W  completed generations since reset/clear.
REQ-015 state  output  2  FSM state: IDLE=00, COUNT=01, COMMIT=10, CLEAR=11.

Function
REQ-016 All outputs SHALL be Moore decodes of registered state: timer_rst=(IDLE), load_en=(COMMIT), clear_en=(CLEAR), busy=!(IDLE).
REQ-017 IDLE: clear -> CLEAR; else step or run -> COUNT; else stay; priority clear > step > run.
REQ-018 On every entry to COUNT, frame counter SHALL load period (0 loads 1); period changes later in the generation ignored.
REQ-019 COUNT: each cycle with tick==7, frame counter decrements; tick==7 with counter==1 -> COMMIT next cycle.
REQ-020 Latency: load_en SHALL rise exactly 8*P cycles after the edge that samples step/run in IDLE (P = effective period).
REQ-021 COMMIT: one cycle; gen_count increments by 1, wrapping all-ones -> 0.
REQ-022 COMMIT exit: pending clear -> CLEAR; else run high -> COUNT (reload); else IDLE.
REQ-023 Timer SHALL keep running through COMMIT -> COUNT so consecutive run-mode load_en strobes are exactly 8*P cycles apart.
REQ-024 clear in COUNT SHALL abort immediately to CLEAR; no load_en, gen_count unchanged before clear.
REQ-025 clear sampled in COMMIT SHALL set a pending flag, honoured on COMMIT exit; flag cleared on CLEAR entry.
REQ-026 step while busy SHALL be ignored (not queued).
REQ-027 run falling during COUNT SHALL finish the current generation (COMMIT) then go to IDLE.
REQ-028 CLEAR: clear_en high exactly 8 cycles (internal 3-bit counter), gen_count set to 0 on entry, then IDLE; clear/step/run ignored while in CLEAR.
REQ-029 Frame counter SHALL be PERIOD_W bits; no underflow (never decrements below 1 in COUNT).

Reset
REQ-030 rst high SHALL asynchronously force state=IDLE, timer_rst=1, load_en=0, clear_en=0, busy=0, gen_count=0, frame counter=0, clear counter=0, pending clear=0.
REQ-031 rst mid-operation (any state) SHALL abort with no further load_en/clear_en pulse; first transition on first posedge after rst falls, per IDLE rules.

Verification
REQ-032 Reset then step one cycle with period=1 -> state COUNT next edge, timer_rst low, load_en high exactly 8 cycles after step sampled for one cycle, gen_count=1, back to IDLE.
REQ-033 run held, period=3 -> load_en pulses every 24 cycles; gen_count 1,2,3 after 3 pulses; period=0 gives 8-cycle spacing.
REQ-034 run high, clear asserted mid-COUNT -> CLEAR next edge, clear_en high 8 cycles, gen_count=0, no load_en, then IDLE (run re-enters COUNT).
REQ-035 clear on COMMIT cycle -> load_en still pulses, gen_count increments, then CLEAR 8 cycles, gen_count=0.
REQ-036 Preload gen_count to all-ones via 2^GEN_W-1 generations (or force) -> next COMMIT wraps to 0.
REQ-037 rst asserted mid-COUNT between edges -> outputs reach reset values without waiting for clk; step ignored while busy; run drop mid-COUNT yields exactly one more load_en.

Source files
------------

// File: rtl/life_gen_controller.sv
// Generation sequencer for a cellular-automaton board: paces generations off an
// external 8-tick timer, strobes cell load/clear, and counts completed generations.
module life_gen_controller #(
   parameter int unsigned GEN_W    = 16,
   parameter int unsigned PERIOD_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic                step,
   input  logic                clear,
   input  logic [PERIOD_W-1:0] period,
   input  logic [2:0]          tick,
   output logic                timer_rst,
   output logic                load_en,
   output logic                clear_en,
   output logic                busy,
   output logic [GEN_W-1:0]    gen_count,
   output logic [1:0]          state
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      COUNT  = 2'b01,
      COMMIT = 2'b10,
      CLEAR  = 2'b11
   } state_t;

   state_t              state_q;
   state_t              state_nxt;
   logic [PERIOD_W-1:0] frame_cnt;
   logic [PERIOD_W-1:0] period_eff;
   logic [2:0]          clr_cnt;
   logic                clear_pend;
   logic                last_frame_c;

   assign period_eff   = (period == '0) ? PERIOD_W'(1) : period;
   assign last_frame_c = (tick == 3'd7) && (frame_cnt == PERIOD_W'(1));
   assign state        = state_q;

   // Next-state selection; clear has priority everywhere except inside CLEAR
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE: begin
            if (clear)
               state_nxt = CLEAR;
            else if (step || run)
               state_nxt = COUNT;
         end
         COUNT: begin
            if (clear)
               state_nxt = CLEAR;
            else if (last_frame_c)
               state_nxt = COMMIT;
         end
         COMMIT: begin
            if (clear || clear_pend)
               state_nxt = CLEAR;
            else if (run)
               state_nxt = COUNT;
            else
               state_nxt = IDLE;
         end
         CLEAR: begin
            if (clr_cnt == 3'd7)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, counters and registered Moore outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         timer_rst  <= 1'b1;
         load_en    <= 1'b0;
         clear_en   <= 1'b0;
         busy       <= 1'b0;
         gen_count  <= '0;
         frame_cnt  <= '0;
         clr_cnt    <= '0;
         clear_pend <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         timer_rst <= (state_nxt == IDLE);
         load_en   <= (state_nxt == COMMIT);
         clear_en  <= (state_nxt == CLEAR);
         busy      <= (state_nxt != IDLE);

         // Period is captured once per generation; the count never drops below 1
         if (state_nxt == COUNT && state_q != COUNT)
            frame_cnt <= period_eff;
         else if (state_q == COUNT && tick == 3'd7 && frame_cnt > PERIOD_W'(1))
            frame_cnt <= frame_cnt - PERIOD_W'(1);

         if (state_nxt == COMMIT && state_q != COMMIT)
            gen_count <= gen_count + GEN_W'(1);

         if (state_q == COMMIT && clear)
            clear_pend <= 1'b1;

         if (state_nxt == CLEAR && state_q != CLEAR) begin
            gen_count  <= '0;
            clr_cnt    <= '0;
            clear_pend <= 1'b0;
         end else if (state_q == CLEAR) begin
            clr_cnt <= clr_cnt + 3'd1;
         end
      end
   end

endmodule
